// File: rtl/two_four_scheduler.sv
// Round-robin scheduler that lends one two/four counter to two requesters for a run of N wraps.
// Optional watchdog abort is built when SCHED_WDOG_EN is defined.
module two_four_scheduler #(
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned WDOG_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             mode0,
  input  logic             mode1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             cnt_z,
  output logic             cnt_x,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             prio_q, prio_d;  // 1 favours req1
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             pick0;

`ifdef SCHED_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
`endif

  assign pick0 = req0 & (~req1 | ~prio_q);

  always_comb begin
    state_d = state_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    prio_d  = prio_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
`ifdef SCHED_WDOG_EN
    wdog_d  = wdog_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt0_d  = pick0;
          gnt1_d  = ~pick0;
          mode_d  = pick0 ? mode0 : mode1;
          rem_d   = pick0 ? len0 : len1;
          state_d = StClear;
        end
      end
      StClear: begin
`ifdef SCHED_WDOG_EN
        wdog_d  = '0;
`endif
        state_d = (rem_q == '0) ? StDone : StRun;
      end
      StRun: begin
        if (cnt_z) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = StDone;
`ifdef SCHED_WDOG_EN
          wdog_d = '0;
        end else if (wdog_q == WdogW'(WDOG_LIMIT - 1)) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        prio_d  = gnt0_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      prio_q  <= 1'b0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
`ifdef SCHED_WDOG_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      prio_q  <= prio_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
`ifdef SCHED_WDOG_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy    = (state_q != StIdle);
  assign cnt_clr = (state_q == StClear);
  assign cnt_en  = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign cnt_x   = busy & mode_q;
  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
`ifdef SCHED_WDOG_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_two_four_scheduler.sv
// Directed bench for two_four_scheduler with a behavioural two/four counter whose terminal
// pulse is registered one cycle after the wrapping enabled cycle.
module tb_two_four_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
  logic [3:0] len0 = '0, len1 = '0;
  logic       cnt_z, cnt_x, cnt_en, cnt_clr, gnt0, gnt1, done, err, busy;
  logic [1:0] cval;
  logic       cz;
  logic       z_kill = 1'b0;
  logic [7:0] outs;
  int         n_checks = 0;
  int         n_errors = 0;
  int         err_seen = 0;

  always #5 clk = ~clk;

  two_four_scheduler #(.LEN_W(4), .WDOG_LIMIT(15)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .mode0  (mode0),
    .mode1  (mode1),
    .len0   (len0),
    .len1   (len1),
    .cnt_z  (cnt_z),
    .cnt_x  (cnt_x),
    .cnt_en (cnt_en),
    .cnt_clr(cnt_clr),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done   (done),
    .err    (err),
    .busy   (busy)
  );

  // Ideal counter: mod-2 or mod-4, terminal pulse registered after the wrapping cycle.
  always @(posedge clk) begin
    if (reset || cnt_clr) begin
      cval <= 2'd0;
      cz   <= 1'b0;
    end else if (cnt_en) begin
      cz   <= !z_kill && (cval == (cnt_x ? 2'd3 : 2'd1));
      cval <= (cval == (cnt_x ? 2'd3 : 2'd1)) ? 2'd0 : cval + 2'd1;
    end else begin
      cz <= 1'b0;
    end
  end
  assign cnt_z = cz;
  assign outs  = {gnt0, gnt1, done, err, cnt_x, cnt_en, cnt_clr, busy};

  always @(negedge clk) if (err === 1'b1) err_seen++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_one(input string tag, input bit k, input logic m, input logic [3:0] l,
                         input int exp_cyc, input int exp_z, input int exp_en,
                         output logic err_at);
    int cyc = 0, z = 0, en = 0, clr = 0, xbad = 0, both = 0, done_cyc = 0;
    bit fin = 0;
    err_at = 1'b0;
    @(negedge clk);
    if (k) begin req1 = 1'b1; mode1 = m; len1 = l; end
    else   begin req0 = 1'b1; mode0 = m; len0 = l; end
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if (k ? gnt1 : gnt0) begin
        cyc++;
        if (cnt_z && cnt_en) z++;
        if (cnt_en) en++;
        if (cnt_clr) clr++;
        if (cnt_x !== m) xbad++;
        if (done) begin
          done_cyc = cyc;
          fin      = 1;
          err_at   = err;
          req0     = 1'b0;
          req1     = 1'b0;
        end
      end
    end
    check_eq({tag, "_finished"}, 32'(fin), 1);
    check_eq({tag, "_done_cyc"}, done_cyc, exp_cyc);
    check_eq({tag, "_z_used"}, z, exp_z);
    check_eq({tag, "_en_cycles"}, en, exp_en);
    check_eq({tag, "_clr_pulses"}, clr, 1);
    check_eq({tag, "_cnt_x_bad"}, xbad, 0);
    check_eq({tag, "_both_gnt"}, both, 0);
    @(negedge clk);
    check_eq({tag, "_idle_outs"}, 32'(outs), 0);
  endtask

  initial begin
    logic e;
    int   seq[4];
    int   ng, gap, both, hold;
    bit   fin, p0, p1, seen_en;

    // Reset
    @(negedge clk);
    check_eq("rst_during", 32'(outs), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_release", 32'(outs), 0);

    // Contention from reset: expect 0,1,0,1 with one IDLE cycle between grants
    req0 = 1'b1; req1 = 1'b1; mode0 = 1'b0; mode1 = 1'b0; len0 = 4'd1; len1 = 4'd1;
    ng = 0; gap = 0; both = 0; fin = 0; p0 = 0; p1 = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if ((gnt0 && !p0) || (gnt1 && !p1)) begin
        if (ng > 0) check_eq("cont_gap", gap, 1);
        if (ng < 4) seq[ng] = gnt1 ? 1 : 0;
        ng++;
        gap = 0;
      end
      if (!busy && ng > 0) gap++;
      if (done && ng == 4) begin
        req0 = 1'b0; req1 = 1'b0; fin = 1;
      end
      p0 = gnt0; p1 = gnt1;
    end
    check_eq("cont_finished", 32'(fin), 1);
    check_eq("cont_g0", seq[0], 0);
    check_eq("cont_g1", seq[1], 1);
    check_eq("cont_g2", seq[2], 0);
    check_eq("cont_g3", seq[3], 1);
    check_eq("cont_both", both, 0);
    @(negedge clk);
    @(negedge clk);

    // Single runs: mode 0 len 3, mode 1 len 2, len 0
    run_one("m0_len3", 1'b0, 1'b0, 4'd3, 9, 3, 7, e);
    check_eq("m0_len3_err", 32'(e), 0);
    run_one("m1_len2", 1'b1, 1'b1, 4'd2, 11, 2, 9, e);
    check_eq("m1_len2_err", 32'(e), 0);
    run_one("len0", 1'b0, 1'b0, 4'd0, 2, 0, 0, e);

`ifdef SCHED_WDOG_EN
    z_kill = 1'b1;
    run_one("wdog", 1'b0, 1'b0, 4'd2, 17, 0, 15, e);
    check_eq("wdog_err", 32'(e), 1);
    z_kill = 1'b0;
`else
    check_eq("err_never", err_seen, 0);
`endif

    // Reset mid-RUN of req1; pointer currently favours req1
    @(negedge clk);
    req1 = 1'b1; mode1 = 1'b1; len1 = 4'd5;
    seen_en = 0;
    for (int i = 0; i < 20 && !seen_en; i++) begin
      @(negedge clk);
      seen_en = cnt_en;
    end
    check_eq("midrst_reached_run", 32'(seen_en), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1; req1 = 1'b0;
    @(negedge clk);
    check_eq("midrst_outs", 32'(outs), 0);
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd0; len1 = 4'd0;
    @(negedge clk);
    check_eq("midrst_prio_g0", 32'(gnt0), 1);
    check_eq("midrst_prio_g1", 32'(gnt1), 0);
    hold = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      hold++;
    end
    check_eq("midrst_len0_done", 32'(done), 1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
